// File: rtl/hit_detector.sv
// Rhythm-game timing judge: grades each new press against a fixed x window,
// holds a hit/miss flag for HOLD_CYCLES and keeps a saturating hit score.
module hit_detector #(
  parameter int unsigned       WIDTH       = 9,
  parameter logic [WIDTH-1:0]  WIN_LO      = 9'd8,
  parameter logic [WIDTH-1:0]  WIN_HI      = 9'd24,
  parameter int unsigned       HOLD_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             go,
  input  logic [WIDTH-1:0] stream,
  output logic             hit,
  output logic             miss,
  output logic [7:0]       score
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD_HIT, HOLD_MISS} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             judged;
  logic             go_q;
  logic [WIDTH-1:0] stream_q;

  logic press, wrap, in_win, accept;

  always_comb begin
    press  = go & ~go_q;
    wrap   = stream > stream_q;
    in_win = (stream >= WIN_LO) && (stream <= WIN_HI);
    // The last hold cycle doubles as the first cycle a new press may be judged.
    accept = press && ((state == IDLE) || (cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state    <= IDLE;
      cnt      <= '0;
      judged   <= 1'b0;
      go_q     <= 1'b1;
      stream_q <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      score    <= '0;
    end else begin
      go_q     <= go;
      stream_q <= stream;
      if (wrap) judged <= 1'b0;
      if (accept) begin
        cnt <= CW'(HOLD_CYCLES - 1);
        if (in_win && !judged) begin
          state  <= HOLD_HIT;
          hit    <= 1'b1;
          miss   <= 1'b0;
          judged <= 1'b1;
          if (score != 8'hFF) score <= score + 8'd1;
        end else begin
          state <= HOLD_MISS;
          hit   <= 1'b0;
          miss  <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (cnt == '0) begin
          state <= IDLE;
          hit   <= 1'b0;
          miss  <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Scoreboard bench for hit_detector: a cycle-indexed judgement model queues the
// expected outputs per edge; a negedge monitor pops and compares.
module tb_hit_detector;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       reset_b = 1'b1;
  logic       go = 1'b0;
  logic [8:0] stream = '0;
  logic       hit, miss;
  logic [7:0] score;

  hit_detector #(.WIDTH(9), .WIN_LO(9'd8), .WIN_HI(9'd24), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_b(reset_b), .go(go), .stream(stream),
    .hit(hit), .miss(miss), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       h;
    logic       m;
    logic [7:0] sc;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: a judgement occupies the outputs for cycles [start, busy_until).
  int  k = 0;
  int  busy_until = 0;
  bit  m_judged = 0;
  bit  m_pgo = 1;
  bit  cur_hit = 0;
  int  m_score = 0;
  int  m_pst = 0;

  task automatic step(input bit r, input bit g, input int s);
    exp_t e;
    bit press, wrap, h;
    reset_b = r;
    go      = g;
    stream  = s[8:0];
    if (r) begin
      busy_until = k;
      m_judged = 0; m_pgo = 1; m_pst = 0; m_score = 0; cur_hit = 0;
    end else begin
      press = g && !m_pgo;
      wrap  = s > m_pst;
      h = 0;
      if (press && k >= busy_until) begin
        h = (s >= 8) && (s <= 24) && !m_judged;
        cur_hit = h;
        busy_until = k + HOLD;
        if (h && m_score < 255) m_score++;
      end
      if (h) m_judged = 1;
      else if (wrap) m_judged = 0;
      m_pgo = g;
      m_pst = s;
    end
    e.h   = (k < busy_until) && cur_hit;
    e.m   = (k < busy_until) && !cur_hit;
    e.sc  = m_score[7:0];
    e.cyc = k;
    q.push_back(e);
    k++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (hit !== e.h || miss !== e.m || score !== e.sc) begin
        failures++;
        $display("FAIL outputs@edge%0d: got hit=%b miss=%b score=%0d, want hit=%b miss=%b score=%0d",
                 e.cyc, hit, miss, score, e.h, e.m, e.sc);
      end
    end
  end

  int cur_s = 0;

  task automatic press_at(input int s);
    cur_s = s;
    step(0, 0, s);
    step(0, 1, s);
    repeat (HOLD + 1) step(0, 0, s);
  endtask

  task automatic wrap_now();
    step(0, 0, 400);
  endtask

  initial begin
    int rs;
    bit rg;
    // Reset with button held; release keeps it held: no press.
    step(1, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);

    // Hits at the window edges.
    press_at(8);
    wrap_now(); press_at(24);
    // Misses just outside and far outside.
    wrap_now(); press_at(7);
    wrap_now(); press_at(25);
    wrap_now(); press_at(100);
    // Double press on one note, then a fresh note.
    wrap_now(); press_at(16);
    press_at(15);
    for (int v = 0; v <= 160; v += 20) step(0, 0, v);
    press_at(16);

    // Held button, then a second rising edge inside the hold.
    wrap_now();
    step(0, 0, 16);
    repeat (20) step(0, 1, 16);
    step(0, 0, 16);
    wrap_now();
    step(0, 1, 16);
    step(0, 0, 16);
    step(0, 1, 16);
    repeat (6) step(0, 0, 16);

    // Back-to-back: rising edge exactly on the hold boundary cycle.
    wrap_now();
    step(0, 1, 10);
    repeat (HOLD - 2) step(0, 1, 10);
    step(0, 0, 10);
    step(0, 1, 30);
    repeat (6) step(0, 0, 30);

    // Saturation.
    for (int unsigned i = 0; i < 260; i++) begin
      wrap_now(); press_at(12);
    end
    // Reset in the middle of a hit hold.
    wrap_now();
    step(0, 1, 12);
    step(0, 0, 12);
    step(1, 0, 12);
    repeat (3) step(0, 0, 12);
    wrap_now(); press_at(20);

    // Randomized traffic around the window.
    rs = 40; rg = 0;
    for (int unsigned i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) rs = $urandom_range(0, 511);
      else if ($urandom_range(0, 3) == 0) rs = $urandom_range(0, 40);
      else if (rs > 0) rs--;
      if ($urandom_range(0, 2) == 0) rg = ~rg;
      step($urandom_range(0, 199) == 0, rg, rs);
    end
    step(0, 0, 0);
    step(0, 0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_detector.md
# hit_detector

Judges timing presses in the rhythm game. It watches the x position of the scrolling note sprite and a player "go" input. On each new press it decides whether the note sits inside a fixed hit window, then flags hit or miss for a visible hold time and keeps a running score. It sits beside the graphics path: `stream` comes from the sprite x-offset counter, `go` from a debounced, inverted push-button, and `hit` drives an LED.

## Interface
Parameters:
- `WIDTH`, 9: width of `stream`.
- `WIN_LO`, 9'd8: lowest x position counted as a hit (inclusive).
- `WIN_HI`, 9'd24: highest x position counted as a hit (inclusive).
- `HOLD_CYCLES`, 25_000_000: number of cycles `hit` or `miss` stays high per judgement. Must be ≥ 1.

Ports:
- `clk`  in  1: the only clock; all logic is rising-edge.
- `reset_b`  in  1: reset, synchronous and active-high despite the suffix. High at a rising edge resets all state.
- `go`  in  1: player press, level, active-high, synchronous to `clk`.
- `stream`  in  WIDTH: current note x position. It decrements toward 0 and then wraps to a larger value.
- `hit`  out  1: judgement was a hit; held high for HOLD_CYCLES.
- `miss`  out  1: judgement was a miss; held high for HOLD_CYCLES.
- `score`  out  8: count of hits, saturating at 255.

## Operation
- Press detection: register `go_q <= go` every cycle. A press is `go & ~go_q`. Holding `go` high generates exactly one press.
- Note tracking: register `stream_q <= stream` every cycle. A new note is when `stream > stream_q` (unsigned), i.e. the wrap. A new note clears the `judged` flag.
- FSM states:
  - IDLE:
    - On a press, sample `stream` in the same cycle.
    - If `WIN_LO <= stream <= WIN_HI` and `judged == 0`: go to HOLD_HIT, set `judged`, and increment `score` unless it is already 255.
    - Otherwise (outside the window, or the note was already judged): go to HOLD_MISS.
  - HOLD_HIT / HOLD_MISS:
    - Load the hold counter with HOLD_CYCLES-1 on entry and decrement it each cycle.
    - Return to IDLE in the cycle after the counter reaches 0.
    - Presses during a hold are ignored: no judgement and no score change. `go_q` still tracks `go`.
- Outputs are registered: `hit` = (state == HOLD_HIT), `miss` = (state == HOLD_MISS). They are never both high.
- Note tracking continues in every state. A wrap during a hold clears `judged` normally.
- A press and a wrap in the same cycle: the judgement uses the pre-clear `judged` value. `judged` is then cleared, or set if the judgement is a hit, with set taking priority.

## Timing
- Reset values: `hit`=0, `miss`=0, `score`=0, state IDLE, counter 0, `judged`=0, `stream_q`=0. `go_q` resets to 1, so a button already held at reset release is not a press.
- Reset mid-hold aborts the hold immediately. Outputs are 0 in the cycle after the reset edge.
- Press latency: with `go` rising so that edge N sees `go`=1 and `go_q`=0, the `hit`/`miss` outputs are high from just after edge N.
- Outputs stay high for exactly HOLD_CYCLES consecutive cycles.
- `score` updates at edge N together with `hit`.
- The earliest next accepted press is at edge N+HOLD_CYCLES. It requires `go` to have fallen and risen again, or a rising edge that lands on that boundary cycle.
- Window comparison is unsigned over the full WIDTH. The boundary values WIN_LO and WIN_HI count as hits; WIN_LO-1 and WIN_HI+1 count as misses.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Reset: assert `reset_b` for 2 cycles with `go`=1, then release while keeping `go`=1. Required: `hit`=`miss`=0, `score`=0, and no press registered.
- Hit at the edges: with `stream`=8, pulse `go`. Required: `hit`=1 for exactly 4 cycles and `score`=1. Repeat after a wrap with `stream`=24. Required: `score`=2.
- Miss outside the window: with `stream`=7, then after a wrap `stream`=25, and also `stream`=100, pulse `go`. Required: `miss`=1 for 4 cycles each time, `hit`=0, and `score` unchanged.
- Double press on one note: with `stream`=16, press (hit, `score`+1), wait for the hold to end, then press again with `stream`=15 and no wrap. Required: `miss`. Then step `stream` from 0 to 160 and back to 16 and press. Required: `hit`.
- Held button and presses during hold: hold `go` high for 20 cycles. Required: exactly one judgement. A second rising edge inside the 4-cycle hold is ignored, with no output or score change.
- Saturation and reset mid-hold: drive 256 hits. Required: `score` stays at 255. Assert reset during HOLD_HIT. Required: `hit`=0 and `score`=0 after the reset edge.
